// File: rtl/vga_pkg.sv
// Shared constants, types and address helper for the 160x120 RGB332 framebuffer
// scanned out at 640x480@60 with 4x4 pixel replication.
package vga_pkg;

  localparam int FB_W      = 160;
  localparam int FB_H      = 120;
  localparam int ADDR_W    = 15;
  localparam int DATA_W    = 8;
  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int LINE_END  = 800;
  localparam int FRAME_END = 525;
  localparam int FB_SIZE   = FB_W * FB_H;

  // Scan-slot positions: column-0 prefetch near line end, last mid-line fetch.
  localparam int SLOT_A_H    = LINE_END - 2;
  localparam int SLOT_B_HMAX = 633;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  // row*160 built from two shifts so no multiplier is inferred
  function automatic addr_t fb_addr(input addr_t row, input addr_t col);
    return (row << 7) + (row << 5) + col;
  endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Write-requester bus: two request/address/data lanes and a one-hot grant pulse.
interface vga_fb_arbiter_if;
  import vga_pkg::*;

  logic [1:0] wr_req;
  addr_t      wr_addr0;
  data_t      wr_data0;
  addr_t      wr_addr1;
  data_t      wr_data1;
  logic [1:0] wr_gnt;

  modport master (
    output wr_req, wr_addr0, wr_data0, wr_addr1, wr_data1,
    input  wr_gnt
  );

  modport slave (
    input  wr_req, wr_addr0, wr_data0, wr_addr1, wr_data1,
    output wr_gnt
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the mask blocks a requester that is being granted
// this cycle so a held request cannot win twice in a row.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  input  logic [1:0] i_mask,
  output logic [1:0] o_gnt
);

  logic       r_ptr;
  logic [1:0] w_elig;

  assign w_elig = i_req & ~i_mask;

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      if (w_elig == 2'b11) begin
        o_gnt = r_ptr ? 2'b10 : 2'b01;
      end else begin
        o_gnt = w_elig;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (o_gnt[0]) begin
      r_ptr <= 1'b1;
    end else if (o_gnt[1]) begin
      r_ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: beam-scheduled scan-out reads own fixed slots,
// every other cycle is handed round-robin to the two game-logic writers.
module vga_fb_arbiter
  import vga_pkg::*;
(
  input  logic              pixel_clk,
  input  logic              rst,
  input  logic [10:0]       hcounter,
  input  logic [10:0]       vcounter,
  vga_fb_arbiter_if.slave   wr,
  output addr_t             ram_addr,
  output logic              ram_we,
  output data_t             ram_wdata,
  input  data_t             ram_rdata,
  output data_t             pixel_rgb,
  output logic              oob_err
);

  logic [10:0] w_next_line;
  logic        w_slot_a;
  logic        w_slot_b;
  logic        w_scan;
  addr_t       w_scan_addr;
  logic [1:0]  w_gnt;
  addr_t       w_wr_addr;
  data_t       w_wr_data;
  logic        w_oob;

  addr_t       r_ram_addr;
  logic        r_ram_we;
  data_t       r_ram_wdata;
  data_t       r_pixel;
  logic        r_oob_err;
  logic [1:0]  r_wr_gnt;
  logic [1:0]  r_rd_pipe;

  assign w_next_line = (vcounter == 11'(FRAME_END)) ? 11'd0 : vcounter + 11'd1;
  assign w_slot_a    = (hcounter == 11'(SLOT_A_H)) && (w_next_line < 11'(V_ACTIVE));
  assign w_slot_b    = (hcounter[1:0] == 2'b01) && (hcounter <= 11'(SLOT_B_HMAX)) &&
                       (vcounter < 11'(V_ACTIVE));
  assign w_scan      = w_slot_a | w_slot_b;

  // Slot B fetches one column ahead so data lands exactly as the beam enters it
  always_comb begin
    w_scan_addr = '0;
    if (w_slot_a) begin
      w_scan_addr = fb_addr(ADDR_W'(w_next_line >> 2), '0);
    end else if (w_slot_b) begin
      w_scan_addr = fb_addr(ADDR_W'(vcounter >> 2), ADDR_W'(hcounter >> 2) + ADDR_W'(1));
    end
  end

  rr_arb2 u_arb (
    .clk    (pixel_clk),
    .rst    (rst),
    .i_en   (!w_scan),
    .i_req  (wr.wr_req),
    .i_mask (r_wr_gnt),
    .o_gnt  (w_gnt)
  );

  assign w_wr_addr = w_gnt[1] ? wr.wr_addr1 : wr.wr_addr0;
  assign w_wr_data = w_gnt[1] ? wr.wr_data1 : wr.wr_data0;
  assign w_oob     = (w_wr_addr >= ADDR_W'(FB_SIZE));

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
      r_pixel     <= '0;
      r_oob_err   <= 1'b0;
      r_wr_gnt    <= 2'b00;
      r_rd_pipe   <= 2'b00;
    end else begin
      r_rd_pipe <= {r_rd_pipe[0], w_scan};
      r_wr_gnt  <= w_gnt;

      if (w_scan) begin
        r_ram_addr <= w_scan_addr;
        r_ram_we   <= 1'b0;
      end else if (|w_gnt) begin
        r_ram_we <= !w_oob;
        if (w_oob) begin
          r_oob_err <= 1'b1;
        end else begin
          r_ram_addr  <= w_wr_addr;
          r_ram_wdata <= w_wr_data;
        end
      end else begin
        r_ram_we <= 1'b0;
      end

      // Column-0 data arrives at LINE_END, inside blanking, so it must beat the blank
      if (r_rd_pipe[1]) begin
        r_pixel <= ram_rdata;
      end else if ((hcounter >= 11'(H_ACTIVE)) || (vcounter >= 11'(V_ACTIVE))) begin
        r_pixel <= '0;
      end
    end
  end

  assign ram_addr   = r_ram_addr;
  assign ram_we     = r_ram_we;
  assign ram_wdata  = r_ram_wdata;
  assign pixel_rgb  = r_pixel;
  assign oob_err    = r_oob_err;
  assign wr.wr_gnt  = r_wr_gnt;

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
Shares a single-port, synchronous-read framebuffer RAM between two requesters. The first is VGA scan-out, driven by the hcounter/vcounter of the 640x480@60 timing generator. The second is two game-logic write requesters. The framebuffer is 160x120 at 8-bit RGB332, and each framebuffer pixel covers a 4x4 block of screen pixels. Scan-out fetches are scheduled deterministically from the beam position and always win their slot. All remaining cycles go to the writers under round-robin arbitration.

Parameters:
FB_W, 160, framebuffer columns
FB_H, 120, framebuffer rows
ADDR_W, 15, framebuffer address width (row*FB_W + col)
DATA_W, 8, pixel width (RGB332)
H_ACTIVE, 640, visible columns
V_ACTIVE, 480, visible lines
LINE_END, 800, last hcounter value (the counter runs 0..LINE_END inclusive)
FRAME_END, 525, last vcounter value

Ports:
pixel_clk  in  1  pixel clock; all logic rises on it
rst  in  1  asynchronous, active-high reset
hcounter  in  11  beam column from timing generator
vcounter  in  11  beam line from timing generator
wr_req  in  2  write request per requester; held until granted
wr_addr0  in  ADDR_W  requester 0 address
wr_data0  in  DATA_W  requester 0 data
wr_addr1  in  ADDR_W  requester 1 address
wr_data1  in  DATA_W  requester 1 data
wr_gnt  out  2  one-cycle grant pulse, one-hot or zero
ram_addr  out  ADDR_W  RAM address (registered)
ram_we  out  1  RAM write enable (registered)
ram_wdata  out  DATA_W  RAM write data (registered)
ram_rdata  in  DATA_W  RAM read data, valid one cycle after address
pixel_rgb  out  DATA_W  scan-out pixel; 0 outside active video
oob_err  out  1  sticky flag: a write address was >= FB_W*FB_H

Behaviour:
- Reset: asynchronous and active-high, as fixed above. While rst=1 all outputs are 0, the round-robin pointer is 0 and the pixel latch is 0. Any in-flight grant or read is discarded.
- A scan slot occurs on an edge that samples either condition below. Every other edge is a write slot.
  - Slot A: hcounter = LINE_END-2 and the next line nl < V_ACTIVE. Here nl = 0 if vcounter = FRAME_END, otherwise vcounter+1. It fetches column 0 of row nl>>2.
  - Slot B: hcounter[1:0] = 2'b01, hcounter <= 633 and vcounter < V_ACTIVE. It fetches column (hcounter>>2)+1 of row vcounter>>2.
- Address arithmetic: row*160 = (row<<7)+(row<<5), computed at ADDR_W bits with no overflow for legal rows.
- Scan pipeline:
  - Edge sampling h: ram_addr and ram_we=0 are registered.
  - Edge sampling h+1: the RAM captures the address.
  - Edge sampling h+2: ram_rdata is latched into pixel_rgb.
  - Result: column c is displayed while hcounter is in 4c..4c+3.
  - pixel_rgb is forced to 0 on any edge that samples hcounter >= H_ACTIVE or vcounter >= V_ACTIVE (except the column-0 latch at hcounter=LINE_END, which loads the first pixel).
- Write slot:
  - Eligible requesters have wr_req=1 and wr_gnt=0 this cycle. This lockout blocks a re-grant while the requester still holds its request during the grant cycle.
  - Selection is round-robin. Priority starts at rr_ptr; after a grant, rr_ptr = granted index + 1 mod 2.
  - The winner's addr/data go into ram_addr/ram_wdata, with ram_we=1 and wr_gnt[i]=1 on the same edge.
  - If no requester is eligible, ram_we=0 and ram_addr holds its value.
- Out-of-range write (addr >= 19200): the request is granted, ram_we stays 0 and oob_err is set. oob_err clears only on reset.
- Simultaneous requests on a write slot: exactly one grant; the other waits. During active video a requester is guaranteed at least 1 grant in 4 cycles while the other requester is also requesting.
- Requesters must hold addr/data stable while wr_req=1 and wr_gnt=0.

Decomposition:
- Shared package vga_pkg holds LINE_END, FRAME_END, H_ACTIVE, V_ACTIVE, FB_W, FB_H, the ADDR_W/DATA_W constants and the scan-slot offsets (LINE_END-2, 633).
- One natural sub-module, rr_arb2: a two-requester round-robin arbiter with an enable input (write slot) and a lockout mask (current wr_gnt).

Test Plan:
1. Reset release at hcounter=0, vcounter=0, RAM preloaded with addr k -> data k[7:0]: line 0 shows pixel_rgb = 0,1,2,...,159, each held for 4 clocks. Line 4 starts at 160 (0xA0).
2. Blanking: at vcounter=480..525, wr_req=2'b01 held -> wr_gnt[0] pulses every other cycle (lockout) and ram_we never collides with a read; pixel_rgb=0 throughout.
3. Both wr_req=2'b11 held during active video -> grants alternate 0,1,0,1 in non-scan slots only. No write occurs on hcounter%4=1 (<=633) or at hcounter=798.
4. wr_addr0=19200 -> wr_gnt[0] pulses, ram_we=0, oob_err=1 and stays 1 until rst.
5. rst asserted mid-line (hcounter=300) while wr_gnt[1]=1 -> all outputs 0 immediately, without waiting for a clock. After release with wr_req=2'b10 still held, requester 1 is re-granted on the first write slot.
6. Frame wrap: vcounter=525, hcounter=798 -> read of address 0 is issued, and pixel_rgb = mem[0] at hcounter=0, vcounter=0.
